// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC sample sequencer.
// FSM state encoding, counter sizing helper and reset-time coefficient defaults.
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } agc_state_t;

    localparam int FILT_RST_DEF = 0;
    localparam int ERR_RST_DEF  = 0;
    localparam int R_RST_DEF    = 0;

    // Wide enough to count up to whichever of the spacing or timeout limits is larger.
    function automatic int agc_cnt_width(input int spacing, input int timeout);
        int m;
        m = (spacing > timeout) ? spacing : timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/agc_cfg_shadow.sv
// Shadow registers for AGC coefficients: writes park in a pending set, applied in one cycle when apply_en is high.
// Latency 1 cycle from pending to live outputs; a write coinciding with apply wins and stays pending.
module agc_cfg_shadow
    import agc_pkg::*;
#(
    parameter int FILTERWIDTH = 13,
    parameter int RWIDTH      = 8,
    parameter int FILT_RST    = FILT_RST_DEF,
    parameter int ERR_RST     = ERR_RST_DEF,
    parameter int R_RST       = R_RST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr,
    input  logic [FILTERWIDTH-1:0] cfg_filter,
    input  logic [FILTERWIDTH-1:0] cfg_error,
    input  logic [RWIDTH-1:0]      cfg_rlevel,
    input  logic                   apply_en,
    output logic                   pend,
    output logic [FILTERWIDTH-1:0] agc_filter,
    output logic [FILTERWIDTH-1:0] agc_error,
    output logic [RWIDTH-1:0]      agc_rlevel
);

    logic [FILTERWIDTH-1:0] pend_filter;
    logic [FILTERWIDTH-1:0] pend_error;
    logic [RWIDTH-1:0]      pend_rlevel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= 1'b0;
            pend_filter <= '0;
            pend_error  <= '0;
            pend_rlevel <= '0;
            agc_filter  <= FILTERWIDTH'(FILT_RST);
            agc_error   <= FILTERWIDTH'(ERR_RST);
            agc_rlevel  <= RWIDTH'(R_RST);
        end else begin
            if (cfg_wr) begin
                // A fresh write defers any apply so the newest values are the ones that land.
                pend        <= 1'b1;
                pend_filter <= cfg_filter;
                pend_error  <= cfg_error;
                pend_rlevel <= cfg_rlevel;
            end else if (apply_en && pend) begin
                pend       <= 1'b0;
                agc_filter <= pend_filter;
                agc_error  <= pend_error;
                agc_rlevel <= pend_rlevel;
            end
        end
    end

endmodule

// File: rtl/agc_sample_sequencer.sv
// Paces I/Q samples into the AGC core (strobes >= SPACING apart), captures results, flags timeout/spurious.
// Result appears 1 cycle after agc_vout; s_ready low whenever a sample is in flight or config is pending.
module agc_sample_sequencer
    import agc_pkg::*;
#(
    parameter int W_IN        = 16,
    parameter int W_IN_MODULE = 26,
    parameter int FILTERWIDTH = 13,
    parameter int RWIDTH      = 8,
    parameter int SPACING     = 40,
    parameter int TIMEOUT     = 255,
    parameter int CNTW        = 16,
    parameter int FILT_RST    = FILT_RST_DEF,
    parameter int ERR_RST     = ERR_RST_DEF,
    parameter int R_RST       = R_RST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [W_IN-1:0]        s_dataI,
    input  logic [W_IN-1:0]        s_dataQ,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [FILTERWIDTH-1:0] cfg_filter,
    input  logic [FILTERWIDTH-1:0] cfg_error,
    input  logic [RWIDTH-1:0]      cfg_rlevel,
    input  logic                   cfg_wr,
    output logic [W_IN-1:0]        agc_dataI,
    output logic [W_IN-1:0]        agc_dataQ,
    output logic                   agc_valid,
    output logic [FILTERWIDTH-1:0] agc_filter,
    output logic [FILTERWIDTH-1:0] agc_error,
    output logic [RWIDTH-1:0]      agc_rlevel,
    input  logic                   agc_vout,
    input  logic [W_IN_MODULE-1:0] agc_outI,
    input  logic [W_IN_MODULE-1:0] agc_outQ,
    output logic [W_IN_MODULE-1:0] m_dataI,
    output logic [W_IN_MODULE-1:0] m_dataQ,
    output logic                   m_valid,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_spurious,
    output logic [CNTW-1:0]        sample_cnt
);

    localparam int CW = agc_cnt_width(SPACING, TIMEOUT);
    // cnt reads 1 in the first WAIT cycle, so leaving at SPACING-2 re-strobes exactly SPACING after ISSUE.
    localparam logic [CW-1:0] SPACE_LIM = CW'(SPACING - 2);
    localparam logic [CW-1:0] TMO_LIM   = CW'(TIMEOUT - 1);

    agc_state_t    state;
    logic [CW-1:0] cnt;
    logic          done;
    logic          pend;

    assign s_ready = (state == IDLE) && enable && !pend;

    agc_cfg_shadow #(
        .FILTERWIDTH (FILTERWIDTH),
        .RWIDTH      (RWIDTH),
        .FILT_RST    (FILT_RST),
        .ERR_RST     (ERR_RST),
        .R_RST       (R_RST)
    ) u_cfg_shadow (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_filter (cfg_filter),
        .cfg_error  (cfg_error),
        .cfg_rlevel (cfg_rlevel),
        .apply_en   (state == IDLE),
        .pend       (pend),
        .agc_filter (agc_filter),
        .agc_error  (agc_error),
        .agc_rlevel (agc_rlevel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            done         <= 1'b0;
            agc_dataI    <= '0;
            agc_dataQ    <= '0;
            agc_valid    <= 1'b0;
            m_dataI      <= '0;
            m_dataQ      <= '0;
            m_valid      <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            agc_valid <= 1'b0;
            m_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (agc_vout) begin
                        err_spurious <= 1'b1;
                    end
                    if (s_valid && s_ready) begin
                        agc_dataI  <= s_dataI;
                        agc_dataQ  <= s_dataQ;
                        agc_valid  <= 1'b1;
                        busy       <= 1'b1;
                        sample_cnt <= sample_cnt + CNTW'(1);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (agc_vout) begin
                        err_spurious <= 1'b1;
                    end
                    cnt   <= CW'(1);
                    done  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (agc_vout) begin
                        if (done) begin
                            err_spurious <= 1'b1;
                        end else begin
                            m_dataI <= agc_outI;
                            m_dataQ <= agc_outQ;
                            m_valid <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                    // A result arriving this cycle counts as done so the spacing limit is still met.
                    if ((done || agc_vout) && cnt >= SPACE_LIM) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!done && !agc_vout && cnt == TMO_LIM) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/agc_sample_sequencer.md
Name: agc_sample_sequencer

Overview:
- Controller in front of the AGC datapath core (Test1). It takes an I/Q stream over a valid/ready handshake and issues single-cycle s_chans_valid strobes to the AGC no closer than SPACING cycles apart.
- Coefficients (Filter/Error/R_level) are held in shadow registers and applied only between samples, when nothing is in flight.
- Captures the AGC result on Valid_Out, forwards it downstream and flags timeouts or spurious results.

Parameters:
W_IN, 16, I/Q input sample width
W_IN_MODULE, 26, AGC result width
FILTERWIDTH, 13, filter/error coefficient width
RWIDTH, 8, reference level width
SPACING, 40, minimum cycles between AGC valid strobes (>=4)
TIMEOUT, 255, max cycles from strobe to Valid_Out before error
CNTW, 16, accepted-sample counter width
FILT_RST / ERR_RST / R_RST, 0 / 0 / 0, coefficient values loaded at reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enable  in  1  permits acceptance of new samples
s_dataI / s_dataQ  in  W_IN  upstream sample
s_valid  in  1  upstream valid
s_ready  out  1  upstream ready
cfg_filter  in  FILTERWIDTH  new filter coefficient
cfg_error  in  FILTERWIDTH  new error coefficient
cfg_rlevel  in  RWIDTH  new reference level
cfg_wr  in  1  one-cycle config write strobe
agc_dataI / agc_dataQ  out  W_IN  to s_chans_dataI/Q
agc_valid  out  1  to s_chans_valid
agc_filter / agc_error  out  FILTERWIDTH  to Filter_Coefficient / Error_Coefficient
agc_rlevel  out  RWIDTH  to R_level
agc_vout  in  1  from Valid_Out
agc_outI / agc_outQ  in  W_IN_MODULE  from OutputI/Q
m_dataI / m_dataQ  out  W_IN_MODULE  registered result
m_valid  out  1  one-cycle result strobe
busy  out  1  sample in flight
err_timeout  out  1  sticky
err_spurious  out  1  sticky
sample_cnt  out  CNTW  accepted samples, wraps modulo 2^CNTW

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; all outputs 0 except agc_filter/agc_error/agc_rlevel, which load FILT_RST/ERR_RST/R_RST. Pending config is discarded.
- A reset asserted mid-operation drops agc_valid immediately and abandons the in-flight sample; no m_valid is produced for it.
- Config shadow:
  - cfg_wr loads the pending registers and sets pend; a second cfg_wr overwrites the pending values.
  - In IDLE with pend=1, pending values move to agc_* outputs in one cycle and pend clears.
  - If cfg_wr coincides with the apply cycle, the new write wins: it stays pending and pend remains 1.
  - agc_* config never changes while busy=1.
- s_ready = (state==IDLE) & enable & ~pend; it is combinational from registered state only.
- States:
  - IDLE -> ISSUE on s_valid & s_ready. The sample is registered, sample_cnt increments.
  - ISSUE (1 cycle): agc_valid=1 with the registered agc_dataI/Q, busy=1. Next state WAIT; the spacing and timeout counters clear.
  - WAIT: busy=1; counters increment each cycle; agc_dataI/Q stay held.
    - On agc_vout: capture agc_outI/Q into m_dataI/Q and pulse m_valid the next cycle; set done.
    - Exit to IDLE when done=1 and at least SPACING cycles have passed since the ISSUE cycle.
    - If TIMEOUT cycles pass after ISSUE with no agc_vout: set err_timeout, return to IDLE, no m_valid.
- Timing under continuous s_valid: accept at cycle N -> agc_valid at N+1 -> next agc_valid at exactly N+1+SPACING, provided agc_vout arrives by cycle N+SPACING-1.
  - A later agc_vout at cycle V moves the next strobe to V+2.
- agc_vout seen in IDLE or ISSUE, or a second agc_vout in the same WAIT: set err_spurious, ignore the data.
- enable deasserted during WAIT: the in-flight sample completes normally; no new accepts until enable returns.
- Errors clear only on rst.

Decomposition:
- agc_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the counter width function clog2(max(SPACING, TIMEOUT)+1);
  - default-coefficient constants.
- One sub-module: agc_cfg_shadow, which holds the pending registers, pend flag, apply logic and reset defaults.

Test Plan:
1. Reset then cfg_wr(filter=100, error=20, rlevel=64) while idle -> agc_filter=100, agc_error=20, agc_rlevel=64 two cycles after the strobe; s_ready low for that apply cycle.
2. 5 samples back-to-back (I=1..5, Q=-1..-5), agc_vout returned 20 cycles after each strobe with I*2, Q*2 -> agc_valid strobes exactly 40 cycles apart; m_valid 5 times carrying 2..10 and -2..-10; sample_cnt=5.
3. cfg_wr(filter=7) during WAIT -> agc_filter unchanged until the cycle after IDLE is entered; the next sample is issued with filter=7.
4. agc_vout withheld -> err_timeout=1 at 255 cycles after the strobe; FSM returns to IDLE; the next sample is accepted; no m_valid.
5. agc_vout in IDLE, then two agc_vout in one WAIT -> err_spurious=1; exactly one m_valid carrying the first result.
6. rst pulsed 10 cycles into WAIT -> busy, agc_valid, m_valid go to 0 at once; coefficients return to defaults; a later agc_vout sets err_spurious.
